// File: rtl/heater_bit_modulator.sv
// Serialises message words MSB-first onto a bank of RO heater enables, holding each bit for a latched
// number of cycles. Accepts one word over valid/ready handshake when idle; abort cancels the word in flight.
module heater_bit_modulator #(
   parameter int DATA_WIDTH   = 32,
   parameter int PERIOD_WIDTH = 32,
   parameter int NUM_HEATERS  = 64,
   localparam int IDX_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    msg_valid,
   output logic                    msg_ready,
   input  logic [DATA_WIDTH-1:0]   msg_data,
   input  logic [PERIOD_WIDTH-1:0] bit_period,
   input  logic                    abort,
   output logic [NUM_HEATERS-1:0]  heat_en,
   output logic                    busy,
   output logic [IDX_WIDTH-1:0]    bit_idx,
   output logic                    done
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic [PERIOD_WIDTH-1:0] period;
   logic [PERIOD_WIDTH-1:0] cycle_cnt;
   logic [PERIOD_WIDTH-1:0] period_eff;
   logic                    accept;

   assign msg_ready = (state == IDLE) & ~abort;
   assign accept    = msg_valid & msg_ready;

   always_comb begin
      period_eff = bit_period;
      if (bit_period == '0)
         period_eff = PERIOD_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         period    <= '0;
         cycle_cnt <= '0;
         heat_en   <= '0;
         busy      <= 1'b0;
         bit_idx   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= SEND;
                  shift_reg <= msg_data;
                  period    <= period_eff;
                  cycle_cnt <= PERIOD_WIDTH'(1);
                  heat_en   <= {NUM_HEATERS{msg_data[DATA_WIDTH-1]}};
                  busy      <= 1'b1;
                  bit_idx   <= IDX_WIDTH'(DATA_WIDTH - 1);
               end
            end
            SEND: begin
               // Abort takes priority even over the final bit completing, so no done pulse.
               if (abort || (cycle_cnt == period && bit_idx == '0)) begin
                  state     <= IDLE;
                  cycle_cnt <= '0;
                  heat_en   <= '0;
                  busy      <= 1'b0;
                  bit_idx   <= '0;
                  done      <= ~abort;
               end else if (cycle_cnt == period) begin
                  shift_reg <= shift_reg << 1;
                  heat_en   <= {NUM_HEATERS{shift_reg[DATA_WIDTH-2]}};
                  bit_idx   <= bit_idx - 1'b1;
                  cycle_cnt <= PERIOD_WIDTH'(1);
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_heater_bit_modulator.sv
// Bench for heater_bit_modulator: cycle-offset reference model compared every cycle, plus literal patterns.
module tb_heater_bit_modulator;
   localparam int DW = 8;
   localparam int PW = 8;
   localparam int NH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          msg_valid = 1'b0;
   logic          msg_ready;
   logic [DW-1:0] msg_data = '0;
   logic [PW-1:0] bit_period = '0;
   logic          abort = 1'b0;
   logic [NH-1:0] heat_en;
   logic          busy;
   logic [2:0]    bit_idx;
   logic          done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   heater_bit_modulator #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .NUM_HEATERS(NH)) dut (
      .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
      .bit_period(bit_period), .abort(abort), .heat_en(heat_en), .busy(busy), .bit_idx(bit_idx),
      .done(done)
   );

   always #5 clk = ~clk;

   // Reference: a word occupies offsets 0 .. DW*P-1 after its accept edge; done follows at offset DW*P.
   bit            m_active = 1'b0;
   bit            m_done = 1'b0;
   logic [DW-1:0] m_word = '0;
   int            m_p = 1;
   int            m_off = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_off    = 0;
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            if (abort) m_active = 1'b0;
            else if (m_off + 1 == DW * m_p) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end else m_off++;
         end else if (msg_valid && !abort) begin
            m_active = 1'b1;
            m_word   = msg_data;
            m_p      = (bit_period == 0) ? 1 : int'(bit_period);
            m_off    = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [NH-1:0] e_heat;
         logic [2:0]    e_idx;
         e_heat = '0;
         e_idx  = '0;
         if (m_active) begin
            e_idx  = 3'(DW - 1 - m_off / m_p);
            e_heat = {NH{m_word[e_idx]}};
         end
         chk("model_heat_en", 32'(heat_en), 32'(e_heat));
         chk("model_busy", 32'(busy), 32'(m_active));
         chk("model_bit_idx", 32'(bit_idx), 32'(e_idx));
         chk("model_done", 32'(done), 32'(m_done));
         chk("model_msg_ready", 32'(msg_ready), 32'(!m_active && !abort));
         if (done === 1'b1) done_cnt++;
      end
   end

   // Call at posedge+2 of the accept edge. pat holds one bit per cycle, first cycle in bit n-1.
   task automatic check_pat(input logic [63:0] pat, input int n, input int drop_at, input string nm);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({nm, "_heat"}, 32'(heat_en), pat[n-1-i] ? 32'hF : 32'h0);
         chk({nm, "_idx"}, 32'(bit_idx), 32'(7 - (i * DW) / n));
         if (i == drop_at) msg_valid = 1'b0;
      end
      @(negedge clk);
      chk({nm, "_done"}, 32'(done), 32'd1);
      chk({nm, "_gap_heat"}, 32'(heat_en), 32'h0);
      chk({nm, "_gap_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic accept_word(input logic [7:0] d, input logic [7:0] bp);
      @(posedge clk); #2;
      msg_data = d; bit_period = bp; msg_valid = 1'b1;
      @(posedge clk); #2;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("async_reset_heat", 32'(heat_en), 32'h0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("idle_heat", 32'(heat_en), 32'h0);
      chk("idle_ready", 32'(msg_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_idx", 32'(bit_idx), 32'd0);

      // A5 at P=3; changing bit_period mid-word must not matter.
      accept_word(8'hA5, 8'd3);
      msg_valid = 1'b0; bit_period = 8'd1;
      check_pat(64'b111000111000000111000111, 24, -1, "a5");

      // 81 with period 0 acts as P=1; valid held with other data during SEND.
      accept_word(8'h81, 8'd0);
      msg_data = 8'h3C;
      check_pat(64'b10000001, 8, 5, "p0");
      chk("p0_no_capture_busy", 32'(busy), 32'd0);

      // FF at P=4, abort while bit_idx = 4 (offsets 12..15).
      accept_word(8'hFF, 8'd4);
      msg_valid = 1'b0;
      repeat (14) @(negedge clk);
      chk("abort_pre_idx", 32'(bit_idx), 32'd4);
      @(posedge clk); #2 abort = 1'b1;
      @(posedge clk); #2;
      chk("abort_heat", 32'(heat_en), 32'h0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_idle_ready", 32'(msg_ready), 32'd0);
      abort = 1'b0;
      #1 chk("abort_ready_back", 32'(msg_ready), 32'd1);

      // Back-to-back F0 then 0F with valid held: second accept in the done cycle.
      done_cnt = 0;
      accept_word(8'hF0, 8'd2);
      msg_data = 8'h0F;
      check_pat(64'hFF00, 16, -1, "b2b_f0");
      @(posedge clk); #2 msg_valid = 1'b0;
      check_pat(64'h00FF, 16, -1, "b2b_0f");
      @(negedge clk);
      chk("b2b_done_pulses", 32'(done_cnt), 32'd2);

      // Asynchronous reset mid-word, then a fresh word.
      accept_word(8'hC3, 8'd5);
      msg_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_heat", 32'(heat_en), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      accept_word(8'h5A, 8'd1);
      msg_valid = 1'b0;
      check_pat(64'b01011010, 8, -1, "post_rst");

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/heater_bit_modulator.md
Name: heater_bit_modulator

Overview:
- Transmitter-side modulator for the temporal thermal covert channel.
- Accepts message words over a valid/ready handshake and serialises them MSB-first.
- Each bit drives a bank of RO heater enables for a programmable number of cycles: '1' means all heaters on, '0' means all heaters off.
- Sits directly upstream of the ro_heater instances; each heat_en bit connects to one heater's enable input.

Parameters:
- DATA_WIDTH, 32, bits per message word; must be >= 2.
- PERIOD_WIDTH, 32, width of the bit-period cycle count.
- NUM_HEATERS, 64, number of heater enable outputs; all carry the same value.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- msg_valid  input  1  a message word is offered.
- msg_ready  output  1  the block can accept a word this cycle.
- msg_data  input  DATA_WIDTH  message word, sent MSB first.
- bit_period  input  PERIOD_WIDTH  cycles per bit; sampled only at accept; a value of 0 is treated as 1.
- abort  input  1  synchronous cancel of the current word.
- heat_en  output  NUM_HEATERS  heater enables; registered.
- busy  output  1  high while a word is being transmitted.
- bit_idx  output  clog2(DATA_WIDTH)  index of the bit currently on heat_en; 0 when idle.
- done  output  1  one-cycle pulse when a word finishes normally.

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - state = IDLE; heat_en = 0, busy = 0, done = 0, bit_idx = 0.
  - All internal registers cleared.
  - msg_ready = 1 once rst deasserts.
- msg_ready is combinational: (state == IDLE) & ~abort.
- Accept occurs on a rising edge where msg_valid & msg_ready are both high. At that edge:
  - latch msg_data into the shift register;
  - latch P = max(bit_period, 1);
  - state = SEND, busy = 1;
  - heat_en = replicate(msg_data[DATA_WIDTH-1]), bit_idx = DATA_WIDTH-1;
  - cycle counter = 1.
- SEND:
  - Each bit is held on heat_en for exactly P cycles.
  - When the cycle counter reaches P and bit_idx > 0: shift left, heat_en takes the next bit, bit_idx decrements, counter resets to 1.
  - When the counter reaches P and bit_idx == 0: next edge goes to IDLE with heat_en = 0, busy = 0, done = 1 for one cycle.
- Timing: for an accept at edge k, heat_en carries the word during cycles k .. k + DATA_WIDTH*P - 1. done is high during cycle k + DATA_WIDTH*P.
- Back-to-back words: a word may be accepted in the done cycle. This guarantees at least one heat_en = 0 cycle between words.
- msg_valid during SEND is ignored; no data is captured.
- bit_period changes during SEND have no effect.
- Abort:
  - In SEND: next edge goes to IDLE with heat_en = 0, busy = 0, bit_idx = 0, and no done pulse.
  - In IDLE: msg_ready is forced low, so no accept occurs.
  - Abort on the same edge as the final bit completing: abort wins, no done.
- The counter compares for equality against the latched P; the maximum P is 2^PERIOD_WIDTH - 1 with no wrap.
- heat_en always equals the replicated current bit or all zeros; no partial bank patterns are ever driven.

Test Plan (DATA_WIDTH = 8, NUM_HEATERS = 4, PERIOD_WIDTH = 8):
- Reset, then idle: heat_en = 4'h0, msg_ready = 1, busy = 0, done = 0, bit_idx = 0.
- Accept 8'hA5 with P = 3:
  - heat_en per cycle = F,F,F,0,0,0,F,F,F,0,0,0,0,0,0,F,F,F,0,0,0,F,F,F;
  - bit_idx steps 7 down to 0;
  - done high exactly at cycle 24 after accept, then heat_en = 0.
- Accept 8'h81 with bit_period = 0:
  - treated as P = 1; heat_en = F,0,0,0,0,0,0,F;
  - done at cycle 8; msg_valid held high during SEND captures nothing.
- Accept 8'hFF with P = 4, assert abort during bit_idx = 4:
  - heat_en = 0 and busy = 0 the next cycle, no done;
  - msg_ready returns to 1 after abort drops.
- msg_valid held high with words 8'hF0 then 8'h0F, P = 2:
  - second word accepted in the done cycle;
  - exactly one heat_en = 0 cycle between the trailing '0' bits of 8'hF0 and the leading bits of 8'h0F;
  - two done pulses in total.
- Assert rst mid-SEND between clock edges: heat_en = 0 and busy = 0 immediately; after release the block accepts a fresh word normally.
